// File: rtl/physical_layer_tx_pkg.sv
// Shared constants and types for the SL3 physical-layer transmit path.
package physical_layer_tx_pkg;

  localparam int NUM_SL3_LANES   = 4;
  localparam int CONN_ID_WIDTH   = 2;
  localparam int LANE_ID_WIDTH   = 2;
  localparam int LANE_DATA_WIDTH = 256;

  typedef struct packed {
    logic [LANE_DATA_WIDTH-1:0] data;
    logic                       valid;
    logic                       last;
  } lane_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SEND,
    ST_DROP
  } tx_state_t;

endpackage

// File: rtl/tx_lane_out_reg.sv
// Single-entry valid/ready output register for one SL3 lane.
module tx_lane_out_reg
  import physical_layer_tx_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  last
);

  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  last_reg;

  // A new load takes priority over draining, so back-to-back words stream at full rate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
      last_reg  <= load_last;
    end else if (ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign last  = last_reg;

endmodule

// File: rtl/physical_layer_tx.sv
// SL3 physical-layer TX: maps each packet's connection to one lane in per-packet
// round-robin of the programmed order IDs, then streams it onto that lane.
module physical_layer_tx
  import physical_layer_tx_pkg::*;
#(
  parameter int NUM_LANES     = NUM_SL3_LANES,
  parameter int DATA_WIDTH    = LANE_DATA_WIDTH,
  parameter int CONN_ID_WIDTH = physical_layer_tx_pkg::CONN_ID_WIDTH,
  parameter int LANE_ID_WIDTH = physical_layer_tx_pkg::LANE_ID_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     program_en,
  input  logic [CONN_ID_WIDTH-1:0] lanes_connection_id [NUM_LANES],
  input  logic [LANE_ID_WIDTH-1:0] lanes_order_id      [NUM_LANES],
  input  logic [LANE_ID_WIDTH-1:0] conn_lane_cnt_m1    [NUM_LANES],
  input  logic [DATA_WIDTH-1:0]    pkt_data,
  input  logic [CONN_ID_WIDTH-1:0] pkt_conn_id,
  input  logic                     pkt_valid,
  input  logic                     pkt_last,
  output logic                     pkt_ready,
  output logic [DATA_WIDTH-1:0]    lane_data [NUM_LANES],
  output logic [NUM_LANES-1:0]     lane_valid,
  output logic [NUM_LANES-1:0]     lane_last,
  input  logic [NUM_LANES-1:0]     lane_ready,
  output logic [15:0]              tx_packets,
  output logic [7:0]               dropped_packets,
  output logic                     program_error
);

  localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  tx_state_t                state_reg;
  logic [CONN_ID_WIDTH-1:0] conn_reg;
  logic [SEL_W-1:0]         sel_reg;
  logic [CONN_ID_WIDTH-1:0] lane_conn_reg  [NUM_LANES];
  logic [LANE_ID_WIDTH-1:0] lane_order_reg [NUM_LANES];
  logic [LANE_ID_WIDTH-1:0] cnt_m1_reg     [NUM_LANES];
  logic [LANE_ID_WIDTH-1:0] rr_cnt_reg     [NUM_LANES];
  logic [15:0]              tx_packets_reg;
  logic [7:0]               dropped_packets_reg;
  logic                     program_error_reg;

  logic                     match_found;
  logic [SEL_W-1:0]         match_idx;
  logic [LANE_ID_WIDTH-1:0] rr_next;
  logic                     word_accept;
  logic [NUM_LANES-1:0]     lane_load;

  // Descending scan so the lowest matching lane index is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_conn_reg[i] == conn_reg && lane_order_reg[i] == rr_cnt_reg[conn_reg]) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
      end
    end
  end

  assign rr_next = (rr_cnt_reg[conn_reg] == cnt_m1_reg[conn_reg]) ? '0
                 : rr_cnt_reg[conn_reg] + LANE_ID_WIDTH'(1);

  always_comb begin
    pkt_ready = 1'b0;
    case (state_reg)
      ST_SEND: pkt_ready = ~lane_valid[sel_reg] | lane_ready[sel_reg];
      ST_DROP: pkt_ready = 1'b1;
      default: pkt_ready = 1'b0;
    endcase
  end

  assign word_accept = pkt_valid & pkt_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg           <= ST_IDLE;
      conn_reg            <= '0;
      sel_reg             <= '0;
      lane_conn_reg       <= '{default: '0};
      lane_order_reg      <= '{default: '0};
      cnt_m1_reg          <= '{default: '0};
      rr_cnt_reg          <= '{default: '0};
      tx_packets_reg      <= '0;
      dropped_packets_reg <= '0;
      program_error_reg   <= 1'b0;
    end else begin
      if (program_en) begin
        if (state_reg == ST_IDLE) begin
          lane_conn_reg  <= lanes_connection_id;
          lane_order_reg <= lanes_order_id;
          cnt_m1_reg     <= conn_lane_cnt_m1;
        end else begin
          program_error_reg <= 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (pkt_valid) begin
            conn_reg  <= pkt_conn_id;
            state_reg <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (match_found) begin
            sel_reg   <= match_idx;
            state_reg <= ST_SEND;
          end else begin
            state_reg <= ST_DROP;
          end
        end
        ST_SEND: begin
          if (word_accept && pkt_last) begin
            rr_cnt_reg[conn_reg] <= rr_next;
            if (tx_packets_reg != '1) tx_packets_reg <= tx_packets_reg + 16'd1;
            state_reg <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (word_accept && pkt_last) begin
            if (dropped_packets_reg != '1) dropped_packets_reg <= dropped_packets_reg + 8'd1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_load[gi] = (state_reg == ST_SEND) && word_accept && (sel_reg == SEL_W'(gi));

    tx_lane_out_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (lane_load[gi]),
      .load_data (pkt_data),
      .load_last (pkt_last),
      .ready     (lane_ready[gi]),
      .data      (lane_data[gi]),
      .valid     (lane_valid[gi]),
      .last      (lane_last[gi])
    );
  end

  assign tx_packets      = tx_packets_reg;
  assign dropped_packets = dropped_packets_reg;
  assign program_error   = program_error_reg;

endmodule

// File: tb/tb_physical_layer_tx.sv
// Self-checking bench for physical_layer_tx: packet vector table plus a per-word scoreboard.
module tb_physical_layer_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         program_en;
  logic [1:0]   lanes_connection_id [4];
  logic [1:0]   lanes_order_id      [4];
  logic [1:0]   conn_lane_cnt_m1    [4];
  logic [255:0] pkt_data;
  logic [1:0]   pkt_conn_id;
  logic         pkt_valid;
  logic         pkt_last;
  logic         pkt_ready;
  logic [255:0] lane_data [4];
  logic [3:0]   lane_valid;
  logic [3:0]   lane_last;
  logic [3:0]   lane_ready;
  logic [15:0]  tx_packets;
  logic [7:0]   dropped_packets;
  logic         program_error;

  physical_layer_tx dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .program_en          (program_en),
    .lanes_connection_id (lanes_connection_id),
    .lanes_order_id      (lanes_order_id),
    .conn_lane_cnt_m1    (conn_lane_cnt_m1),
    .pkt_data            (pkt_data),
    .pkt_conn_id         (pkt_conn_id),
    .pkt_valid           (pkt_valid),
    .pkt_last            (pkt_last),
    .pkt_ready           (pkt_ready),
    .lane_data           (lane_data),
    .lane_valid          (lane_valid),
    .lane_last           (lane_last),
    .lane_ready          (lane_ready),
    .tx_packets          (tx_packets),
    .dropped_packets     (dropped_packets),
    .program_error       (program_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           lane;
    logic [255:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    logic [1:0] conn;
    int         nwords;
    int         lane;   // -1: packet must be dropped
    int         tx;
    int         drop;
  } vec_t;

  exp_t sb [$];
  exp_t mon_e;
  vec_t vecs [12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pkt_seq  = 0;
  bit   mon_en   = 1'b1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Every word leaving a lane is matched against the next expected word.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_valid[i] && lane_ready[i]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: lane %0d emitted %0h, required nothing", i, lane_data[i]);
          end else begin
            mon_e = sb.pop_front();
            check("word_lane", 256'(i), 256'(mon_e.lane));
            check("word_data", lane_data[i], mon_e.data);
            check("word_last", 256'(lane_last[i]), 256'(mon_e.last));
          end
        end
      end
    end
  end

  task automatic send_pkt(input logic [1:0] conn, input int nwords, input int exp_lane);
    int  budget;
    bit  accepted;
    pkt_seq++;
    for (int w = 0; w < nwords; w++) begin
      pkt_valid   = 1'b1;
      pkt_last    = (w == nwords - 1);
      pkt_conn_id = (w == 0) ? conn : ~conn;
      pkt_data    = {160'(pkt_seq), 32'(w), 32'hC0DE_0000, 32'($urandom)};
      if (exp_lane >= 0) sb.push_back('{exp_lane, pkt_data, pkt_last});
      budget   = 0;
      accepted = 1'b0;
      while (!accepted && budget < 60) begin
        @(negedge clk);
        accepted = pkt_ready;
        budget++;
      end
      if (!accepted) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: pkt %0d word %0d not accepted, required acceptance", pkt_seq, w);
      end
      @(posedge clk); #1;
    end
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_lane(input int l);
    int cyc = 0;
    @(negedge clk);
    while (!lane_valid[l] && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!lane_valid[l]) begin
      n_fail++;
      $display("FAIL wait_lane: lane %0d valid stayed 0, required 1", l);
    end
  endtask

  task automatic program_table();
    @(posedge clk); #1;
    lanes_connection_id = '{2'd0, 2'd0, 2'd1, 2'd1};
    lanes_order_id      = '{2'd0, 2'd1, 2'd0, 2'd1};
    conn_lane_cnt_m1    = '{2'd1, 2'd1, 2'd0, 2'd0};
    program_en = 1'b1;
    @(posedge clk); #1;
    program_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pkt_ready"}, 256'(pkt_ready), 256'(0));
    check({tag, "_lane_valid"}, 256'(lane_valid), 256'(0));
    check({tag, "_lane_last"}, 256'(lane_last), 256'(0));
    for (int i = 0; i < 4; i++) check({tag, "_lane_data"}, lane_data[i], 256'(0));
    check({tag, "_tx_packets"}, 256'(tx_packets), 256'(0));
    check({tag, "_dropped"}, 256'(dropped_packets), 256'(0));
    check({tag, "_program_error"}, 256'(program_error), 256'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n               = 1'b0;
    program_en          = 1'b0;
    lanes_connection_id = '{default: 2'd0};
    lanes_order_id      = '{default: 2'd0};
    conn_lane_cnt_m1    = '{default: 2'd0};
    pkt_data            = '0;
    pkt_conn_id         = '0;
    pkt_valid           = 1'b0;
    pkt_last            = 1'b0;
    lane_ready          = 4'hF;

    // conn, words, lane, tx_packets, dropped_packets after the packet
    vecs[0]  = '{2'd0, 1, 0, 1, 0};
    vecs[1]  = '{2'd0, 3, 1, 2, 0};
    vecs[2]  = '{2'd0, 2, 0, 3, 0};
    vecs[3]  = '{2'd0, 1, 1, 4, 0};
    vecs[4]  = '{2'd1, 2, 2, 5, 0};
    vecs[5]  = '{2'd0, 1, 0, 6, 0};
    vecs[6]  = '{2'd1, 1, 3, 7, 0};
    vecs[7]  = '{2'd0, 2, 1, 8, 0};
    vecs[8]  = '{2'd1, 1, 2, 9, 0};
    vecs[9]  = '{2'd3, 3, -1, 9, 1};
    vecs[10] = '{2'd2, 1, -1, 9, 2};
    vecs[11] = '{2'd0, 1, 0, 10, 2};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    program_table();
    @(negedge clk);
    check("program_error_idle_load", 256'(program_error), 256'(0));

    foreach (vecs[k]) begin
      send_pkt(vecs[k].conn, vecs[k].nwords, vecs[k].lane);
      wait_drain($sformatf("vec%0d", k));
      check($sformatf("vec%0d_tx_packets", k), 256'(tx_packets), 256'(vecs[k].tx));
      check($sformatf("vec%0d_dropped", k), 256'(dropped_packets), 256'(vecs[k].drop));
    end

    // Backpressure: lane 3 stalls for three cycles mid-packet.
    fork
      send_pkt(2'd1, 5, 3);
      begin
        wait_lane(3);
        @(posedge clk); #1;
        lane_ready[3] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_pkt_ready", 256'(pkt_ready), 256'(0));
          check("stall_lane_valid", 256'(lane_valid[3]), 256'(1));
        end
        @(posedge clk); #1;
        lane_ready[3] = 1'b1;
      end
    join
    wait_drain("stall");
    check("stall_tx_packets", 256'(tx_packets), 256'(11));

    // A load attempted mid-packet must be refused and flagged.
    fork
      send_pkt(2'd0, 4, 1);
      begin
        wait_lane(1);
        @(posedge clk); #1;
        lanes_connection_id = '{default: 2'd2};
        program_en = 1'b1;
        @(posedge clk); #1;
        program_en = 1'b0;
      end
    join
    wait_drain("prog_in_send");
    check("prog_in_send_error", 256'(program_error), 256'(1));
    send_pkt(2'd0, 1, 0);
    wait_drain("table_kept");
    check("table_kept_tx_packets", 256'(tx_packets), 256'(13));

    // Reset while a packet is streaming on lane 1.
    mon_en = 1'b0;
    @(posedge clk); #1;
    pkt_valid   = 1'b1;
    pkt_last    = 1'b0;
    pkt_conn_id = 2'd0;
    pkt_data    = 256'hDEAD_BEEF;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midpkt_lane1_valid", 256'(lane_valid[1]), 256'(1));
    @(posedge clk); #1;
    rst_n     = 1'b0;
    pkt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("midpkt_reset");
    mon_en = 1'b1;
    program_table();

    // Fresh packet after reset: order-0 lane, first word out three edges after valid.
    @(posedge clk); #1;
    pkt_valid   = 1'b1;
    pkt_last    = 1'b1;
    pkt_conn_id = 2'd0;
    pkt_data    = 256'h1234_5678_9ABC;
    sb.push_back('{0, pkt_data, 1'b1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("latency_not_yet_valid", 256'(lane_valid[0]), 256'(0));
    check("latency_send_ready", 256'(pkt_ready), 256'(1));
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    @(negedge clk);
    check("latency_lane0_valid", 256'(lane_valid[0]), 256'(1));
    wait_drain("post_reset");
    check("post_reset_tx_packets", 256'(tx_packets), 256'(1));
    check("post_reset_program_error", 256'(program_error), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/physical_layer_tx.md
# physical_layer_tx

Transmit side of the SL3 physical layer: accepts whole packets from the network layer, resolves the packet's connection ID to one physical lane, and streams the packet onto that lane. Lanes of a connection are used in strict per-packet round-robin of their programmed order ID, which is the sequence the receiving physical layer expects. The block sits between the network-layer TX packet FIFO and the per-lane TX units that feed the SL3 transceivers.

## Interface
- NUM_LANES, 4, number of SL3 lanes
- DATA_WIDTH, 256, packet word width
- CONN_ID_WIDTH, 2, connection ID width
- LANE_ID_WIDTH, 2, lane order ID / lane count width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- program_en  in  1  load lane table this cycle
- lanes_connection_id  in  [NUM_LANES] x CONN_ID_WIDTH  connection owning lane i
- lanes_order_id  in  [NUM_LANES] x LANE_ID_WIDTH  order of lane i within its connection
- conn_lane_cnt_m1  in  [NUM_LANES] x LANE_ID_WIDTH  lanes per connection c, minus one (indexed by connection ID)
- pkt_data  in  DATA_WIDTH  packet word
- pkt_conn_id  in  CONN_ID_WIDTH  destination connection; sampled on the packet's first word only
- pkt_valid / pkt_last  in  1  word valid / last word of packet
- pkt_ready  out  1  word accepted when pkt_valid & pkt_ready
- lane_data  out  [NUM_LANES] x DATA_WIDTH  per-lane word
- lane_valid / lane_last  out  [NUM_LANES] x 1  per-lane valid / last
- lane_ready  in  [NUM_LANES] x 1  per-lane ready
- tx_packets  out  16  packets fully sent (saturating)
- dropped_packets  out  8  packets discarded as unmapped (saturating)
- program_error  out  1  sticky: program_en seen outside IDLE

## Operation
- Lane table (connection_id, order_id per lane; lane count per connection) is registered on program_en in IDLE only. In any other state the load is ignored and program_error is set; it clears only on reset.
- Per-connection round-robin counter rr_cnt[c], reset 0.
- FSM states: IDLE, SELECT, SEND, DROP.
- IDLE: pkt_ready=0. On pkt_valid, latch pkt_conn_id and go to SELECT.
- SELECT: pkt_ready=0. Find lane i with connection_id[i]==conn and order_id[i]==rr_cnt[conn].
  - If several lanes match, the lowest index wins. Register it as sel and go to SEND.
  - If none match, go to DROP.
- SEND: pkt_ready = ~lane_valid[sel] | lane_ready[sel]. Each accepted word is loaded into lane sel's output register with data and last.
  - On accepting the last word: rr_cnt[conn] increments, wrapping to 0 after conn_lane_cnt_m1[conn]; tx_packets increments; FSM returns to IDLE.
- DROP: pkt_ready=1. Words are discarded. On the last word, dropped_packets increments, rr_cnt is unchanged, and the FSM returns to IDLE.
- Per-lane output register: lane_valid[i] clears when lane_ready[i] is high and no new load arrives that cycle. A lane's register keeps holding after the FSM leaves SEND until that lane drains.
- A single-word packet (first word has pkt_last=1) is legal in both SEND and DROP.

## Timing
- Reset values: pkt_ready=0, all lane_valid=0, lane_last=0, lane_data=0, tx_packets=0, dropped_packets=0, program_error=0, FSM=IDLE, table all-zero.
- First word of a packet is on lane_data 3 cycles after pkt_valid rises, assuming lane ready (IDLE→SELECT→SEND accept→output register).
- SEND throughput is 1 word/cycle while lane_ready[sel]=1.
- Inter-packet gap is 2 cycles (IDLE, SELECT).
- Counters saturate at all-ones.
- rr_cnt and table values are used modulo field width; a count above the number of programmed lanes leads to DROP on unmatched indices.
- Deasserting rst_n mid-packet aborts the packet immediately. Downstream sees lane_valid drop with no last, which is accepted behaviour.

## Structure
- The shared net package holds CONN_ID_WIDTH, LANE_ID_WIDTH, NUM_SL3_LANES and a lane word typedef (data, valid, last). This block takes its defaults from there.
- One sub-module, tx_lane_out_reg: a single-entry valid/ready output register, instantiated NUM_LANES times.
- Lane match logic is a combinational priority search inside the top.

## Test plan
- Table maps lanes 0,1 → conn 0 (order 0,1) and lanes 2,3 → conn 1 (order 0,1); conn_lane_cnt_m1={1,1}. Send 4 packets to conn 0 -> lanes 0,1,0,1 in turn; tx_packets=4.
- Interleave packets to conn 1 and conn 0 -> conn 1 goes to lane 2 then 3, unaffected by conn 0's counter.
- 5-word packet; lane_ready[sel] low on cycles 2–4 -> pkt_ready low while the register is full; all 5 words arrive in order, last set only on word 5.
- pkt_conn_id=3 with no lane mapped -> all words accepted, no lane_valid, dropped_packets=1, rr_cnt unchanged.
- program_en pulsed during SEND -> table unchanged, program_error=1, packet completes on the original lane.
- Reset mid-packet, then a fresh packet -> all outputs at reset values, rr_cnt=0, new packet goes to the order-0 lane. The table must be reprogrammed after reset.
